not_gate_response_checker: RTL and testbench

// - Synthesizable response checker for a unit under test that behaves as a NOT gate; the receiving end of the stimulus path.
// - Latches each stimulus bit and waits a programmable settle time.
// - Samples the unit's output and compares it with the inverted stimulus.
// - Keeps pass/fail counts, a sticky error flag and the last observed values.
// - Sits beside the stimulus source; lets a NOT-gate test run self-checking in hardware as well as in simulation.

---
 rtl/not_gate_response_checker_if.sv | 35 +++
 rtl/not_gate_response_checker.sv | 129 ++++++++++++
 tb/tb_not_gate_response_checker.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/not_gate_response_checker_if.sv
// Bundle between a NOT-gate stimulus source and its response checker.
// Handshake: a stimulus transfers on a rising clk edge where stim_valid and
// ready are both high; stim_valid without ready is simply not taken (no
// back-pressure queueing), and ready never depends on stim_valid.
interface not_gate_response_checker_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             stop;
  logic             stim_valid;
  logic             stim_in;
  logic             dut_out;
  logic             ready;
  logic             busy;
  logic             result_valid;
  logic             result_pass;
  logic             last_expected;
  logic             last_observed;
  logic [CNT_W-1:0] pass_count;
  logic [CNT_W-1:0] fail_count;
  logic             error_flag;
  logic             done;

  modport master (
    output start, stop, stim_valid, stim_in, dut_out,
    input  ready, busy, result_valid, result_pass, last_expected,
           last_observed, pass_count, fail_count, error_flag, done
  );

  modport slave (
    input  start, stop, stim_valid, stim_in, dut_out,
    output ready, busy, result_valid, result_pass, last_expected,
           last_observed, pass_count, fail_count, error_flag, done
  );
endinterface

// File: rtl/not_gate_response_checker.sv
// Response checker for a NOT-gate unit under test: latches a stimulus bit,
// waits SETTLE_CYCLES, samples the unit's output and scores it against the
// inverted stimulus. All outputs are registered; dbg_state mirrors the FSM.
module not_gate_response_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  not_gate_response_checker_if.slave   bus,
  output logic [2:0]                   dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t     state;
  logic [7:0] settle_cnt;
  logic       stim_q;
  logic       stop_pending;
  logic       expected_bit;
  logic       mismatch;

  assign dbg_state    = state;
  assign expected_bit = ~stim_q;
  // Case inequality so an X/Z response from the unit scores as a failure.
  assign mismatch     = (bus.dut_out !== expected_bit);

  // Checker FSM with all handshake, status and scoreboard outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IDLE;
      settle_cnt        <= '0;
      stim_q            <= 1'b0;
      stop_pending      <= 1'b0;
      bus.ready         <= 1'b0;
      bus.busy          <= 1'b0;
      bus.result_valid  <= 1'b0;
      bus.result_pass   <= 1'b0;
      bus.last_expected <= 1'b0;
      bus.last_observed <= 1'b0;
      bus.pass_count    <= '0;
      bus.fail_count    <= '0;
      bus.error_flag    <= 1'b0;
      bus.done          <= 1'b0;
    end else begin
      bus.result_valid <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state             <= S_ARMED;
            stop_pending      <= 1'b0;
            bus.ready         <= 1'b1;
            bus.done          <= 1'b0;
            bus.result_pass   <= 1'b0;
            bus.last_expected <= 1'b0;
            bus.last_observed <= 1'b0;
            bus.pass_count    <= '0;
            bus.fail_count    <= '0;
            bus.error_flag    <= 1'b0;
          end
        end
        S_ARMED: begin
          if (bus.stim_valid) begin
            // A stop arriving with the stimulus waits until the check is scored.
            state        <= S_SETTLE;
            stim_q       <= bus.stim_in;
            settle_cnt   <= SETTLE_LOAD;
            stop_pending <= bus.stop;
            bus.ready    <= 1'b0;
            bus.busy     <= 1'b1;
          end else if (bus.stop) begin
            state     <= S_DONE;
            bus.ready <= 1'b0;
            bus.done  <= 1'b1;
          end
        end
        S_SETTLE: begin
          if (bus.stop) begin
            stop_pending <= 1'b1;
          end
          if (settle_cnt == 8'd0) begin
            state <= S_CHECK;
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end
        S_CHECK: begin
          bus.result_valid  <= 1'b1;
          bus.result_pass   <= ~mismatch;
          bus.last_expected <= expected_bit;
          bus.last_observed <= bus.dut_out;
          if (mismatch) begin
            bus.error_flag <= 1'b1;
            if (bus.fail_count != CNT_MAX) begin
              bus.fail_count <= bus.fail_count + 1'b1;
            end
          end else if (bus.pass_count != CNT_MAX) begin
            bus.pass_count <= bus.pass_count + 1'b1;
          end
          bus.busy <= 1'b0;
          if (stop_pending || bus.stop) begin
            state        <= S_DONE;
            stop_pending <= 1'b0;
            bus.done     <= 1'b1;
          end else begin
            state     <= S_ARMED;
            bus.ready <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          bus.ready <= 1'b0;
          bus.busy  <= 1'b0;
          bus.done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_not_gate_response_checker.sv
// Bench for not_gate_response_checker: one 8-bit-counter instance and one
// 2-bit-counter instance share the same stimulus; a counting reference model
// and an expected-value queue predict every observed output.
module tb_not_gate_response_checker;

  localparam int S = 2;

  logic       clk;
  logic       reset;
  logic [2:0] dbg_a;
  logic [2:0] dbg_b;

  not_gate_response_checker_if #(.CNT_W(8)) bus_a ();
  not_gate_response_checker_if #(.CNT_W(2)) bus_b ();

  assign bus_b.start      = bus_a.start;
  assign bus_b.stop       = bus_a.stop;
  assign bus_b.stim_valid = bus_a.stim_valid;
  assign bus_b.stim_in    = bus_a.stim_in;
  assign bus_b.dut_out    = bus_a.dut_out;

  not_gate_response_checker #(.SETTLE_CYCLES(S), .CNT_W(8)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_a.slave),
    .dbg_state (dbg_a)
  );

  not_gate_response_checker #(.SETTLE_CYCLES(S), .CNT_W(2)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_b.slave),
    .dbg_state (dbg_b)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  int         n_vec = 0;
  int         n_err = 0;
  logic [0:0] exp_q[$];
  int         m_pass, m_fail;
  logic       m_err, m_le, m_lo, m_rp, m_ready, m_done;

  function automatic int sat(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_clear();
    m_pass = 0; m_fail = 0;
    m_err = 1'b0; m_le = 1'b0; m_lo = 1'b0; m_rp = 1'b0;
  endtask

  task automatic check_state();
    chk("ready",         8'(bus_a.ready),         8'(m_ready));
    chk("done",          8'(bus_a.done),          8'(m_done));
    chk("busy",          8'(bus_a.busy),          8'd0);
    chk("result_pass",   8'(bus_a.result_pass),   8'(m_rp));
    chk("last_expected", 8'(bus_a.last_expected), 8'(m_le));
    chk("last_observed", {7'd0, bus_a.last_observed}, {7'd0, m_lo});
    chk("pass_count",    bus_a.pass_count,        8'(sat(m_pass, 8)));
    chk("fail_count",    bus_a.fail_count,        8'(sat(m_fail, 8)));
    chk("error_flag",    8'(bus_a.error_flag),    8'(m_err));
    chk("pass_count_w2", 8'(bus_b.pass_count),    8'(sat(m_pass, 2)));
    chk("fail_count_w2", 8'(bus_b.fail_count),    8'(sat(m_fail, 2)));
    chk("error_flag_w2", 8'(bus_b.error_flag),    8'(m_err));
  endtask

  // Driver: start pulse (from IDLE or DONE)
  task automatic do_start();
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    model_clear();
    m_ready = 1'b1;
    m_done  = 1'b0;
    check_state();
  endtask

  // Driver: one stimulus, optionally with a competing stim_valid during
  // settle and/or stop alongside acceptance; result must land exactly S+2
  // edges after acceptance.
  task automatic apply_vector(input logic stim, input logic dout,
                              input bit glitch, input bit stop_with);
    logic e;
    logic ok;
    bus_a.stim_valid = 1'b1;
    bus_a.stim_in    = stim;
    bus_a.dut_out    = dout;
    bus_a.stop       = stop_with;
    exp_q.push_back(~stim);
    tick();
    bus_a.stim_valid = 1'b0;
    bus_a.stop       = 1'b0;
    chk("accept_busy",  8'(bus_a.busy),  8'd1);
    chk("accept_ready", 8'(bus_a.ready), 8'd0);
    for (int k = 1; k <= S + 4; k++) begin
      bus_a.stim_valid = glitch && (k == 1);
      bus_a.stim_in    = ~stim;
      tick();
      bus_a.stim_valid = 1'b0;
      chk("result_valid", 8'(bus_a.result_valid), 8'(k == S + 2));
      chk("busy",         8'(bus_a.busy),         8'(k <= S + 1));
      if (k == S + 2) begin
        e  = exp_q.pop_front();
        ok = (dout === e);
        if (ok) m_pass++;
        else begin
          m_fail++;
          m_err = 1'b1;
        end
        m_le = e;
        m_lo = dout;
        m_rp = ok;
        chk("last_expected_at_result", 8'(bus_a.last_expected), 8'(e));
      end
    end
    m_ready = !stop_with;
    m_done  = stop_with;
    check_state();
  endtask

  // Directed and randomized sequence
  initial begin
    logic s;
    logic d;
    bus_a.start = 1'b0; bus_a.stop = 1'b0; bus_a.stim_valid = 1'b0;
    bus_a.stim_in = 1'b0; bus_a.dut_out = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    model_clear();
    m_ready = 1'b0; m_done = 1'b0;
    check_state();
    chk("reset_result_valid", 8'(bus_a.result_valid), 8'd0);
    reset = 1'b0;
    tick();

    do_start();
    apply_vector(1'b0, 1'b1, 1'b0, 1'b0);    // pass
    apply_vector(1'b1, 1'b1, 1'b0, 1'b0);    // stuck-at-1 fail
    apply_vector(1'b0, 1'b1, 1'b0, 1'b0);    // pass, error stays sticky
    apply_vector(1'b1, 1'b0, 1'b1, 1'b0);    // competing stim during settle
    for (int i = 0; i < 5; i++) begin       // saturate the 2-bit counter
      s = 1'($urandom_range(0, 1));
      apply_vector(s, s, 1'b0, 1'b0);
    end
    apply_vector(1'b0, 1'bx, 1'b0, 1'b0);    // unknown response scores as fail
    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom_range(0, 1));
      d = ($urandom_range(0, 9) < 7) ? ~s : s;
      apply_vector(s, d, bit'($urandom_range(0, 1)), 1'b0);
    end

    apply_vector(1'b1, 1'b0, 1'b0, 1'b1);    // stop with stimulus
    do_start();
    apply_vector(1'b1, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of SETTLE aborts the check silently
    bus_a.stim_valid = 1'b1;
    bus_a.stim_in    = 1'b0;
    bus_a.dut_out    = 1'b1;
    tick();
    bus_a.stim_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    model_clear();
    m_ready = 1'b0; m_done = 1'b0;
    check_state();
    for (int k = 0; k < S + 4; k++) begin
      tick();
      chk("abort_result_valid", 8'(bus_a.result_valid), 8'd0);
    end

    // Stimulus and stop are ignored in IDLE
    bus_a.stim_valid = 1'b1;
    bus_a.stop       = 1'b1;
    tick();
    bus_a.stim_valid = 1'b0;
    bus_a.stop       = 1'b0;
    check_state();
    for (int k = 0; k < S + 4; k++) begin
      tick();
      chk("idle_result_valid", 8'(bus_a.result_valid), 8'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
